// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-RAM arbiter.
package mem_arbiter_pkg;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Which requester holds (or last held) the RAM port.
   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_ME = 1'b1
   } owner_e;

   // Byte-lane masks; reads always present an empty mask to the RAM.
   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch (IF) and the
// memory stage (ME). Each access is sequenced IDLE -> WAIT -> RESP with a watchdog
// that aborts a WAIT that never sees an acknowledge.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   // Instruction-fetch requester
   input  logic                  if_r_enable_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_r_data_o,
   output logic                  if_busy_o,
   output logic                  if_done_o,
   // Memory-stage requester
   input  logic                  me_r_enable_i,
   input  logic                  me_w_enable_i,
   input  logic [3:0]            me_w_mask_i,
   input  logic [DATA_WIDTH-1:0] me_w_data_i,
   input  logic [ADDR_WIDTH-1:0] me_addr_i,
   output logic [DATA_WIDTH-1:0] me_r_data_o,
   output logic                  me_busy_o,
   output logic                  me_done_o,
   // RAM / UART-facing port
   output logic                  mem_enable_o,
   output logic                  mem_we_o,
   output logic [3:0]            mem_mask_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_w_data_o,
   input  logic [DATA_WIDTH-1:0] mem_r_data_i,
   input  logic                  mem_ack_i,
   output logic                  err_o
);

   // Clears the two byte-offset bits of a fetch address.
   localparam logic [ADDR_WIDTH-1:0] WordAlign = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   arb_state_e            state_q;
   owner_e                owner_q;
   owner_e                last_owner_q;
   logic                  we_q;
   logic [3:0]            mask_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [31:0]           cnt_q;
   logic                  mem_en_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] me_rdata_q;

   logic        if_req;
   logic        me_req;
   logic        grant_me;
   logic [31:0] cnt_inc;
   logic        timeout_hit;
   logic        in_wait;

   // Request decode, round-robin tie-break and watchdog compare.
   always_comb begin
      if_req      = if_r_enable_i;
      me_req      = me_r_enable_i | me_w_enable_i;
      // On a tie the requester that did not own the last access wins.
      grant_me    = me_req & (~if_req | (last_owner_q == OWNER_IF));
      cnt_inc     = cnt_q + 32'd1;
      timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT);
      in_wait     = (state_q == ARB_WAIT);
   end

   // Access sequencer: grant/latch in IDLE, wait for ack or watchdog, one RESP cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         owner_q      <= OWNER_IF;
         last_owner_q <= OWNER_IF;
         we_q         <= 1'b0;
         mask_q       <= MASK_NONE;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         mem_en_q     <= 1'b0;
         err_q        <= 1'b0;
         if_rdata_q   <= '0;
         me_rdata_q   <= '0;
      end else begin
         mem_en_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            ARB_IDLE: begin
               if (if_req || me_req) begin
                  state_q  <= ARB_WAIT;
                  mem_en_q <= 1'b1;
                  cnt_q    <= '0;
                  if (grant_me) begin
                     owner_q <= OWNER_ME;
                     // A simultaneous read+write request is treated as a write.
                     we_q    <= me_w_enable_i;
                     mask_q  <= me_w_enable_i ? me_w_mask_i : MASK_NONE;
                     addr_q  <= me_addr_i;
                     wdata_q <= me_w_data_i;
                  end else begin
                     owner_q <= OWNER_IF;
                     we_q    <= 1'b0;
                     mask_q  <= MASK_NONE;
                     addr_q  <= if_addr_i & WordAlign;
                     wdata_q <= '0;
                  end
               end
            end
            ARB_WAIT: begin
               if (mem_ack_i) begin
                  state_q      <= ARB_RESP;
                  last_owner_q <= owner_q;
                  if (!we_q) begin
                     if (owner_q == OWNER_IF) if_rdata_q <= mem_r_data_i;
                     else                     me_rdata_q <= mem_r_data_i;
                  end
               end else if (timeout_hit) begin
                  // Abort: complete the handshake with a zero word and flag the error.
                  state_q      <= ARB_RESP;
                  last_owner_q <= owner_q;
                  err_q        <= 1'b1;
                  if (owner_q == OWNER_IF) if_rdata_q <= '0;
                  else                     me_rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            ARB_RESP: state_q <= ARB_IDLE;
            default:  state_q <= ARB_IDLE;
         endcase
      end
   end

   // Port drive; write enable and mask are only asserted while the access is outstanding.
   always_comb begin
      mem_enable_o = mem_en_q;
      mem_we_o     = in_wait & we_q;
      mem_mask_o   = in_wait ? mask_q : MASK_NONE;
      mem_addr_o   = addr_q;
      mem_w_data_o = wdata_q;
      if_busy_o    = in_wait;
      me_busy_o    = in_wait;
      if_done_o    = (state_q == ARB_RESP) && (owner_q == OWNER_IF);
      me_done_o    = (state_q == ARB_RESP) && (owner_q == OWNER_ME);
      if_r_data_o  = if_rdata_q;
      me_r_data_o  = me_rdata_q;
      err_o        = err_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each request pushes its expected RAM access;
// the monitor pops it on the issue strobe and checks the completion that follows.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_r_enable_i;
   logic [AW-1:0] if_addr_i;
   logic [DW-1:0] if_r_data_o;
   logic          if_busy_o;
   logic          if_done_o;
   logic          me_r_enable_i;
   logic          me_w_enable_i;
   logic [3:0]    me_w_mask_i;
   logic [DW-1:0] me_w_data_i;
   logic [AW-1:0] me_addr_i;
   logic [DW-1:0] me_r_data_o;
   logic          me_busy_o;
   logic          me_done_o;
   logic          mem_enable_o;
   logic          mem_we_o;
   logic [3:0]    mem_mask_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_w_data_o;
   logic [DW-1:0] mem_r_data_i;
   logic          mem_ack_i;
   logic          err_o;

   mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_r_enable_i (if_r_enable_i),
      .if_addr_i     (if_addr_i),
      .if_r_data_o   (if_r_data_o),
      .if_busy_o     (if_busy_o),
      .if_done_o     (if_done_o),
      .me_r_enable_i (me_r_enable_i),
      .me_w_enable_i (me_w_enable_i),
      .me_w_mask_i   (me_w_mask_i),
      .me_w_data_i   (me_w_data_i),
      .me_addr_i     (me_addr_i),
      .me_r_data_o   (me_r_data_o),
      .me_busy_o     (me_busy_o),
      .me_done_o     (me_done_o),
      .mem_enable_o  (mem_enable_o),
      .mem_we_o      (mem_we_o),
      .mem_mask_o    (mem_mask_o),
      .mem_addr_o    (mem_addr_o),
      .mem_w_data_o  (mem_w_data_o),
      .mem_r_data_i  (mem_r_data_i),
      .mem_ack_i     (mem_ack_i),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   // One expected RAM access; dly < 0 means the RAM never acknowledges.
   typedef struct {
      logic          is_me;
      logic [AW-1:0] addr;
      logic          we;
      logic [3:0]    mask;
      logic [DW-1:0] wdata;
      int            dly;
      logic [DW-1:0] rd;
   } acc_t;

   acc_t          acc_q[$];
   acc_t          cur;
   int            n_vec = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            issue_cyc = 0;
   int            wait_cnt = 0;
   int            n_issue = 0;
   int            if_hold = 0;
   logic          in_flight = 1'b0;
   logic [DW-1:0] exp_if_rd = '0;
   logic [DW-1:0] exp_me_rd = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   // Advance one cycle, then monitor outputs and play the RAM's ack.
   task automatic tick();
      logic exp_err;
      @(posedge clk);
      #1;
      cyc++;
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
         check_eq("issue_expected", 32'(acc_q.size() != 0), 32'd1);
         if (acc_q.size() != 0) begin
            cur       = acc_q.pop_front();
            in_flight = 1'b1;
            wait_cnt  = 0;
            issue_cyc = cyc;
            n_issue++;
         end
      end
      if (in_flight && (if_busy_o || me_busy_o)) begin
         check_eq("wait_addr", mem_addr_o, cur.addr);
         check_eq("wait_we", 32'(mem_we_o), 32'(cur.we));
         check_eq("wait_mask", 32'(mem_mask_o), 32'(cur.mask));
         check_eq("wait_wdata", mem_w_data_o, cur.wdata);
         check_eq("wait_busy", 32'({if_busy_o, me_busy_o}), 32'd3);
         check_eq("enable_once", 32'(mem_enable_o), 32'(wait_cnt == 0));
         if (cur.dly >= 0 && wait_cnt == cur.dly) begin
            mem_ack_i    = 1'b1;
            mem_r_data_i = cur.rd;
         end
         wait_cnt++;
      end
      if (if_done_o || me_done_o || err_o) begin
         if (!in_flight) begin
            check_eq("done_unexpected", 32'({if_done_o, me_done_o, err_o}), 32'd0);
         end else begin
            exp_err = (cur.dly < 0);
            check_eq("if_done", 32'(if_done_o), 32'(!cur.is_me));
            check_eq("me_done", 32'(me_done_o), 32'(cur.is_me));
            check_eq("err", 32'(err_o), 32'(exp_err));
            check_eq("latency", 32'(cyc - issue_cyc), exp_err ? 32'(TO) : 32'(cur.dly + 1));
            if (exp_err) begin
               if (cur.is_me) exp_me_rd = '0;
               else           exp_if_rd = '0;
            end else if (!cur.we) begin
               if (cur.is_me) exp_me_rd = cur.rd;
               else           exp_if_rd = cur.rd;
            end
            check_eq("if_r_data", if_r_data_o, exp_if_rd);
            check_eq("me_r_data", me_r_data_o, exp_me_rd);
            if (cur.is_me) begin
               me_r_enable_i = 1'b0;
               me_w_enable_i = 1'b0;
            end else if (if_hold > 0) begin
               if_hold--;
            end else begin
               if_r_enable_i = 1'b0;
            end
            in_flight = 1'b0;
         end
      end
   endtask

   task automatic req_if(input logic [AW-1:0] addr, input int dly, input logic [DW-1:0] rd);
      acc_t a;
      if_r_enable_i = 1'b1;
      if_addr_i     = addr;
      a.is_me = 1'b0;
      a.addr  = {addr[AW-1:2], 2'b00};
      a.we    = 1'b0;
      a.mask  = 4'b0000;
      a.wdata = '0;
      a.dly   = dly;
      a.rd    = rd;
      acc_q.push_back(a);
   endtask

   // Read enable is raised for writes too, so a store also exercises write-wins.
   task automatic req_me(input logic we, input logic [AW-1:0] addr, input logic [3:0] mask,
                         input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] rd);
      acc_t a;
      me_r_enable_i = 1'b1;
      me_w_enable_i = we;
      me_addr_i     = addr;
      me_w_mask_i   = mask;
      me_w_data_i   = wd;
      a.is_me = 1'b1;
      a.addr  = addr;
      a.we    = we;
      a.mask  = we ? mask : 4'b0000;
      a.wdata = wd;
      a.dly   = dly;
      a.rd    = rd;
      acc_q.push_back(a);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((in_flight || acc_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_in_budget", 32'(in_flight || acc_q.size() != 0), 32'd0);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_port"}, 32'({mem_enable_o, mem_we_o, mem_mask_o}), 32'd0);
      check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
      check_eq({tag, "_wdata"}, mem_w_data_o, 32'd0);
      check_eq({tag, "_hs"}, 32'({if_busy_o, if_done_o, me_busy_o, me_done_o, err_o}), 32'd0);
      check_eq({tag, "_if_rd"}, if_r_data_o, 32'd0);
      check_eq({tag, "_me_rd"}, me_r_data_o, 32'd0);
   endtask

   initial begin
      int base;
      rst           = 1'b1;
      if_r_enable_i = 1'b0;
      if_addr_i     = '0;
      me_r_enable_i = 1'b0;
      me_w_enable_i = 1'b0;
      me_w_mask_i   = '0;
      me_w_data_i   = '0;
      me_addr_i     = '0;
      mem_r_data_i  = '0;
      mem_ack_i     = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      rst = 1'b0;
      tick();

      // ME load, ack in the issue cycle.
      req_me(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF);
      drain(20);
      tick();

      // ME store with read enable also high, ack on the 4th WAIT cycle.
      req_me(1'b1, 32'h0000_0202, 4'b0100, 32'h5A5A_5A5A, 3, 32'h0BAD_0BAD);
      drain(20);
      tick();

      // Tie after an ME access: IF first, then ME while IF keeps requesting, then IF.
      if_hold = 1;
      req_if(32'h0000_1003, 1, 32'h1111_2222);
      req_me(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 0, 32'h3333_4444);
      req_if(32'h0000_1003, 2, 32'h5555_6666);
      drain(40);
      tick();
      check_eq("tie_if_released", 32'(if_r_enable_i), 32'd0);

      // Watchdog abort, then a late ack that must be ignored.
      req_me(1'b0, 32'h0000_0400, 4'b0000, 32'h0, -1, 32'h0);
      drain(20);
      tick();
      tick();
      mem_ack_i    = 1'b1;
      mem_r_data_i = 32'hCAFE_F00D;
      base = n_issue;
      repeat (3) tick();
      check_eq("late_ack_busy", 32'(me_busy_o), 32'd0);
      check_eq("late_ack_rdata", me_r_data_o, 32'd0);
      check_eq("late_ack_issue", 32'(n_issue - base), 32'd0);

      // Reset in the second WAIT cycle.
      req_if(32'h0000_2000, -1, 32'h0);
      for (int i = 0; i < 5 && !in_flight; i++) tick();
      check_eq("rst_issue_seen", 32'(in_flight), 32'd1);
      tick();
      rst           = 1'b1;
      if_r_enable_i = 1'b0;
      in_flight     = 1'b0;
      exp_if_rd     = '0;
      exp_me_rd     = '0;
      tick();
      check_quiet("mid_rst");
      rst = 1'b0;
      tick();
      mem_ack_i    = 1'b1;
      mem_r_data_i = 32'h7777_8888;
      repeat (3) tick();
      check_eq("post_rst_busy", 32'(if_busy_o | me_busy_o), 32'd0);
      check_eq("post_rst_rdata", if_r_data_o, 32'd0);

      // Back-to-back IF fetches.
      base = n_issue;
      req_if(32'h0000_3000, 0, 32'hA0A0_0001);
      drain(20);
      tick();
      req_if(32'h0000_3004, 0, 32'hA0A0_0002);
      drain(20);
      repeat (3) tick();
      check_eq("b2b_issue_count", 32'(n_issue - base), 32'd2);
      check_eq("b2b_idle", 32'(if_busy_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
